// File: rtl/picocode_pkg.sv
// Shared definitions for the picocode program-memory loader: FSM states,
// default geometry and the bytes-per-word helper.
package picocode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 32'sd18;
  localparam int DEF_ADDR_W = 32'sd10;

  function automatic int calc_bpw(input int data_w);
    return (data_w + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/picocode_sp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// with enable and a synchronous clear that forces the read data to zero.
module picocode_sp_ram #(
  parameter int DATA_W = 32'sd18,
  parameter int ADDR_W = 32'sd10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage array: no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; clr wins over a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (clr) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/picocode_loader_ram.sv
// CPU program RAM with a length-prefixed byte-stream loader that holds the CPU
// in reset until an image is accepted. Define PICOCODE_CKSUM_EN for a checksum byte.
module picocode_loader_ram
  import picocode_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_rst,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int BPW    = calc_bpw(DATA_W);
  localparam int BCNT_W = (BPW > 32'sd1) ? $clog2(BPW) : 32'sd1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPW - 32'sd1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(32'sd1);
  localparam logic [16:0]       DEPTH_L   = 17'(32'sd1 << ADDR_W);

  state_t              state_r;
  logic [7:0]          hdr_hi_r;
  logic [16:0]         n_r;
  logic [16:0]         word_cnt_r;
  logic [BCNT_W-1:0]   byte_cnt_r;
  logic [DATA_W-1:0]   acc_r;
  logic [7:0]          sum_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic                cpu_rst_r;

  logic                xfer_s;
  logic [16:0]         hdr_n_s;
  logic                hdr_bad_s;
  logic                last_word_s;
  logic [DATA_W-1:0]   acc_next_s;
  logic [7:0]          sum_next_s;
  logic                we_s;

  // Only the low DATA_W bits of the MSB-first packed word survive the shift.
  assign xfer_s      = byte_valid && busy_r;
  assign hdr_n_s     = {1'b0, hdr_hi_r, byte_data};
  assign hdr_bad_s   = (hdr_n_s == 17'd0) || (hdr_n_s > DEPTH_L);
  assign last_word_s = ((word_cnt_r + 17'd1) == n_r);
  assign acc_next_s  = DATA_W'({acc_r, byte_data});
  assign sum_next_s  = sum_r + byte_data;

  // Word write strobe on the final byte of each word
  always_comb begin
    we_s = 1'b0;
    if (xfer_s && (state_r == ST_DATA) && (byte_cnt_r == LAST_BYTE)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Loader FSM with its counters, packer, checksum and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hdr_hi_r   <= 8'd0;
      n_r        <= 17'd0;
      word_cnt_r <= 17'd0;
      byte_cnt_r <= '0;
      acc_r      <= '0;
      sum_r      <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cpu_rst_r  <= 1'b1;
    end else begin
      done_r <= 1'b0;
      // Release the CPU the cycle after the done pulse; a new load_req overrides below.
      if (done_r) begin
        cpu_rst_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (load_req) begin
            state_r    <= ST_HDR_HI;
            busy_r     <= 1'b1;
            err_r      <= 1'b0;
            cpu_rst_r  <= 1'b1;
            word_cnt_r <= 17'd0;
            byte_cnt_r <= '0;
            acc_r      <= '0;
            sum_r      <= 8'd0;
          end
        end
        ST_HDR_HI: begin
          if (xfer_s) begin
            hdr_hi_r <= byte_data;
            state_r  <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (xfer_s) begin
            if (hdr_bad_s) begin
              err_r   <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              n_r     <= hdr_n_s;
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            acc_r <= acc_next_s;
            sum_r <= sum_next_s;
            if (byte_cnt_r == LAST_BYTE) begin
              byte_cnt_r <= '0;
              word_cnt_r <= word_cnt_r + 17'd1;
              if (last_word_s) begin
`ifdef PICOCODE_CKSUM_EN
                state_r <= ST_CKSUM;
`else
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
`endif
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + BCNT_ONE;
            end
          end
        end
`ifdef PICOCODE_CKSUM_EN
        ST_CKSUM: begin
          if (xfer_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            if (byte_data == sum_r) begin
              done_r <= 1'b1;
            end else begin
              err_r  <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  picocode_sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (word_cnt_r[ADDR_W-1:0]),
    .wdata (acc_next_s),
    .re    (cpu_en),
    .clr   (cpu_rst_r),
    .raddr (cpu_addr),
    .rdata (instruction)
  );

  assign byte_ready = busy_r;
  assign load_busy  = busy_r;
  assign load_done  = done_r;
  assign load_err   = err_r;
  assign cpu_rst    = cpu_rst_r;

endmodule

// File: tb/tb_picocode_loader_ram.sv
// Bench for picocode_loader_ram: default 18x1024 instance plus an 8x16 instance.
// Build with PICOCODE_CKSUM_EN to exercise the checksum byte.
module tb_picocode_loader_ram;

  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int BPW   = 3;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, load_req, byte_valid, byte_ready, cpu_en;
  logic [7:0]    byte_data;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] instruction;
  logic          cpu_rst, load_busy, load_done, load_err;

  logic          s_load_req, s_byte_valid, s_byte_ready, s_cpu_en;
  logic [7:0]    s_byte_data, s_instruction;
  logic [3:0]    s_cpu_addr;
  logic          s_cpu_rst, s_load_busy, s_load_done, s_load_err;

  picocode_loader_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .cpu_en(cpu_en),
    .cpu_addr(cpu_addr), .instruction(instruction), .cpu_rst(cpu_rst),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err));

  picocode_loader_ram #(.DATA_W(8), .ADDR_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .load_req(s_load_req), .byte_valid(s_byte_valid),
    .byte_data(s_byte_data), .byte_ready(s_byte_ready), .cpu_en(s_cpu_en),
    .cpu_addr(s_cpu_addr), .instruction(s_instruction), .cpu_rst(s_cpu_rst),
    .load_busy(s_load_busy), .load_done(s_load_done), .load_err(s_load_err));

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, s_done_cnt = 0, bad_rst_cnt = 0, done_base = 0;

  logic [DW-1:0] model [DEPTH];
  logic [23:0]   fixed_w[$];
  logic [23:0]   last_w[$];
`ifdef PICOCODE_CKSUM_EN
  logic [7:0]    ck_adj = 8'h00;
`endif

  typedef struct {
    int n;
    bit exp_err;
    int gap_max;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clk) begin
    if (load_done) done_cnt <= done_cnt + 1;
    if (s_load_done) s_done_cnt <= s_done_cnt + 1;
    if (rst_n && load_busy && !cpu_rst) bad_rst_cnt <= bad_rst_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    waited = 0;
    while (!byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Build the byte image from the header/word rules and stream it.
  task automatic do_load(input int n, input int gap_max, input int mid_at);
    logic [7:0]  q[$];
    logic [7:0]  sum;
    logic [23:0] raw;
    logic [15:0] n16;
    n16 = n[15:0];
    sum = 8'h00;
    done_base = done_cnt;
    last_w.delete();
    q.push_back(n16[15:8]);
    q.push_back(n16[7:0]);
    if (n >= 1 && n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        raw = (w < fixed_w.size()) ? fixed_w[w] : 24'($urandom);
        last_w.push_back(raw);
        model[w] = raw[DW-1:0];
        for (int b = BPW - 1; b >= 0; b--) begin
          q.push_back(raw[b*8 +: 8]);
          sum = sum + raw[b*8 +: 8];
        end
      end
`ifdef PICOCODE_CKSUM_EN
      q.push_back(sum + ck_adj);
`endif
    end
    pulse_req();
    for (int i = 0; i < q.size(); i++) begin
      if (i == mid_at) pulse_req();
      send_byte(q[i], $urandom_range(gap_max, 0));
    end
  endtask

  task automatic read_word(input int a, output logic [DW-1:0] d);
    cpu_en   = 1'b1;
    cpu_addr = a[AW-1:0];
    @(negedge clk);
    d = instruction;
    cpu_en = 1'b0;
  endtask

  task automatic expect_end(input string name, input bit exp_err);
    logic [DW-1:0] d;
    repeat (2) @(negedge clk);
    check({name, "_err"}, load_err, exp_err);
    check({name, "_cpu_rst"}, cpu_rst, exp_err);
    check({name, "_busy"}, {load_busy, byte_ready}, 2'b00);
    check({name, "_done_cnt"}, done_cnt - done_base, exp_err ? 0 : 1);
    if (exp_err) begin
      read_word(0, d);
      check({name, "_instr_in_rst"}, d, 18'h0);
    end
  endtask

  task automatic verify_image(input string name, input int n);
    logic [DW-1:0] d;
    int bad;
    bad = 0;
    for (int a = 0; a < n; a++) begin
      read_word(a, d);
      if (d !== model[a]) bad++;
    end
    check({name, "_image_mismatches"}, bad, 0);
  endtask

  task automatic s_send(input logic [7:0] b);
    int waited;
    s_byte_valid = 1'b1;
    s_byte_data  = b;
    waited = 0;
    while (!s_byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("s_byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_byte_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [7:0]    s_model[16];
    logic [7:0]    s_sum;
    int            bad, base;

    rst_n = 1'b0; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    cpu_en = 1'b0; cpu_addr = '0;
    s_load_req = 1'b0; s_byte_valid = 1'b0; s_byte_data = 8'h00;
    s_cpu_en = 1'b0; s_cpu_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_instruction", instruction, 18'h0);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_flags", {load_busy, load_done, load_err}, 3'b000);
    check("rst_small_cpu_rst", s_cpu_rst, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Two known words; check the done pulse and cpu_rst release timing.
    fixed_w = '{24'h031234, 24'h0000AB};
    do_load(2, 0, -1);
    check("t1_done_pulse", load_done, 1'b1);
    check("t1_cpu_rst_held", cpu_rst, 1'b1);
    @(negedge clk);
    check("t1_done_cleared", load_done, 1'b0);
    check("t1_cpu_rst_fell", cpu_rst, 1'b0);
    check("t1_done_count", done_cnt - done_base, 1);
    read_word(0, d);
    check("t1_addr0", d, 18'h31234);
    read_word(1, d);
    check("t1_addr1", d, 18'h000AB);
    @(negedge clk);
    check("t1_hold_when_disabled", instruction, 18'h000AB);
    fixed_w.delete();

    // Bad headers must not write; addr 1 still holds the earlier word.
    do_load(0, 0, -1);
    expect_end("t2_n0", 1'b1);
    do_load(1025, 0, -1);
    expect_end("t2_n1025", 1'b1);
    do_load(1, 0, -1);
    expect_end("t2_recover", 1'b0);
    verify_image("t2_no_write", 2);

`ifdef PICOCODE_CKSUM_EN
    do_load(4, 2, -1);
    expect_end("t3_good_ck", 1'b0);
    verify_image("t3_good_ck", 4);
    fixed_w = last_w;
    ck_adj  = 8'h01;
    do_load(4, 2, -1);
    expect_end("t3_bad_ck", 1'b1);
    ck_adj  = 8'h00;
    fixed_w.delete();
    repeat (3) @(negedge clk);
    check("t3_cpu_rst_stays", cpu_rst, 1'b1);
`endif

    vecs[0] = '{0,     1'b1, 0};
    vecs[1] = '{1025,  1'b1, 2};
    vecs[2] = '{65535, 1'b1, 1};
    vecs[3] = '{1,     1'b0, 3};
    vecs[4] = '{7,     1'b0, 5};
    vecs[5] = '{40,    1'b0, 1};
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].n, vecs[i].gap_max, -1);
      expect_end($sformatf("vec%0d", i), vecs[i].exp_err);
      if (!vecs[i].exp_err) verify_image($sformatf("vec%0d", i), vecs[i].n);
    end

    // load_req pulses while busy (in header and in data) are ignored.
    do_load(6, 5, 5);
    expect_end("t4_mid_data_req", 1'b0);
    verify_image("t4_mid_data_req", 6);
    do_load(3, 5, 1);
    expect_end("t4_mid_hdr_req", 1'b0);
    verify_image("t4_mid_hdr_req", 3);

    // Reset during DATA, then a full-depth reload.
    pulse_req();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", {load_busy, byte_ready}, 2'b00);
    check("t5_rst_cpu_rst", cpu_rst, 1'b1);
    check("t5_rst_flags", {load_done, load_err}, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_idle_after_rst", byte_ready, 1'b0);
    base = bad_rst_cnt;
    do_load(DEPTH, 0, -1);
    expect_end("t5_full", 1'b0);
    check("t5_cpu_rst_during_load", bad_rst_cnt - base, 0);
    read_word(DEPTH - 1, d);
    check("t5_addr1023", d, model[DEPTH-1]);
    verify_image("t5_full", DEPTH);

    // 8-bit, 16-word instance: one byte per word.
    s_sum = 8'h00;
    s_load_req = 1'b1;
    @(negedge clk);
    s_load_req = 1'b0;
    s_send(8'h00);
    s_send(8'h10);
    for (int i = 0; i < 16; i++) begin
      s_model[i] = 8'($urandom);
      s_sum = s_sum + s_model[i];
      s_send(s_model[i]);
    end
`ifdef PICOCODE_CKSUM_EN
    s_send(s_sum);
`endif
    repeat (2) @(negedge clk);
    check("t6_done_cnt", s_done_cnt, 1);
    check("t6_status", {s_cpu_rst, s_load_err, s_load_busy}, 3'b000);
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      s_cpu_en   = 1'b1;
      s_cpu_addr = a[3:0];
      @(negedge clk);
      if (s_instruction !== s_model[a]) bad++;
    end
    s_cpu_en = 1'b0;
    check("t6_image_mismatches", bad, 0);
    s_load_req = 1'b1;
    @(negedge clk);
    s_load_req = 1'b0;
    s_send(8'h00);
    s_send(8'h11);
    repeat (2) @(negedge clk);
    check("t6_n17_err", {s_load_err, s_cpu_rst, s_load_busy}, 3'b110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
